cbrt_seq: RTL and testbench
===========================

Name: cbrt_seq

Overview:
Iterative unsigned integer cube-root unit, y = floor(cbrt(b)). It is the responder side of the team's start_i/busy_o operand handshake: an initiator, either a bench or the "fun" datapath controller, drives operands and start, then waits for busy to fall. It uses a shift-add digit-recurrence algorithm with an internal bit-serial multiplier, with no combinational multipliers.

Parameters:
WIDTH, 8, operand width of b_bi and width of the internal remainder register; must be >= 3
ITER, (WIDTH-1)/3+1 (derived localparam, 3 for WIDTH=8), number of root digits computed
LAT, ITER*(WIDTH+2) (derived localparam, 30 for WIDTH=8), busy cycles per operation

Ports:
clk_i  input  1  clock; all state changes on rising edge
rst_i  input  1  reset; asynchronous, active-low (0 = reset)
start_i  input  1  request; sampled only in IDLE
b_bi  input  WIDTH  radicand; captured on the accepting edge
busy_o  output  1  high while computing
y_bo  output  WIDTH  root; zero-extended, stable while busy_o=0

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, busy_o=0, y_bo=0, internal x/y/s/multiplier registers=0.
- Accept: in IDLE, start_i=1 at a rising edge latches x<=b_bi, y<=0, s<=3*(ITER-1), busy_o<=1, state<=SHIFT.
  - start_i is ignored while busy_o=1.
  - Operand changes after the accepting edge have no effect.
- SHIFT (1 cycle): y<=y<<1; multiplier loads mcand=y_new, mplier=y_new+1, acc=0, cnt=0; state<=MUL.
- MUL (WIDTH cycles): shift-add, one multiplier bit per cycle; acc holds y*(y+1) after cnt reaches WIDTH-1; state<=CMP.
- CMP (1 cycle):
  - t = (3*acc+1) << s, evaluated at 2*WIDTH+2 bits (no truncation).
  - If x >= t: x<=x-t and y<=y+1.
  - If s==0: state<=DONE. Otherwise s<=s-3 and state<=SHIFT.
- DONE: y_bo<=y and busy_o<=0 on the same edge; state<=IDLE.
  - The total number of rising edges with busy_o=1 is exactly LAT (30).
  - A new start_i may be accepted on the first edge after busy_o falls (back-to-back allowed).
- y_bo holds its last result until the next DONE. It is not cleared when a new start is accepted.
- Reset asserted mid-operation aborts immediately: busy_o=0, y_bo=0, no partial result is emitted.
- Boundaries:
  - b=0 gives y=0.
  - b=2^WIDTH-1 gives the max root (6 for WIDTH=8).
  - Perfect cubes give the exact root.
  - Values one below a cube round down, e.g. 63 gives 3.
- Result is bit-exact against floor(cbrt(b)) for all 2^WIDTH inputs.

Optional Feature:
CBRT_SEQ_REM_EN
- Defined: adds output rem_bo [WIDTH-1:0] = b - y^3, i.e. the final x. It is updated in DONE together with y_bo, and reset to 0.
- Undefined: no rem_bo port. The x register is still required internally.
- Latency is identical in both builds.

Test Plan:
- Reset then start with b=0 -> busy_o high for exactly 30 edges, then y_bo=0 (rem_bo=0 if enabled).
- b=27, 64, 125, 216 in sequence, back-to-back starts -> y_bo=3, 4, 5, 6; each busy window is 30 cycles with no idle gap beyond 1 cycle.
- b=26, 63, 255 -> y_bo=2, 3, 6; rem_bo=18, 36, 39 when CBRT_SEQ_REM_EN is defined.
- Start with b=8; at cycle 5 of busy, pulse start_i with b=125 -> second start ignored, y_bo=2, busy_o never re-extends.
- Start with b=125; deassert rst_i at cycle 12 of busy -> busy_o and y_bo drop to 0 asynchronously. After release, start with b=1 gives y_bo=1.
- Exhaustive sweep b=0..255 with a reference model -> zero mismatches, every busy window exactly 30 cycles.

Source files
------------

// File: rtl/cbrt_seq_if.sv
// Operand handshake bundle for cbrt_seq: initiator drives start_i/b_bi, responder returns busy_o/y_bo.
// rem_bo exists only when CBRT_SEQ_REM_EN is defined.
interface cbrt_seq_if #(
   parameter int WIDTH = 8
);
   logic             start_i;
   logic [WIDTH-1:0] b_bi;
   logic             busy_o;
   logic [WIDTH-1:0] y_bo;
`ifdef CBRT_SEQ_REM_EN
   logic [WIDTH-1:0] rem_bo;

   modport master (output start_i, b_bi, input busy_o, y_bo, rem_bo);
   modport slave  (input start_i, b_bi, output busy_o, y_bo, rem_bo);
`else
   modport master (output start_i, b_bi, input busy_o, y_bo);
   modport slave  (input start_i, b_bi, output busy_o, y_bo);
`endif
endinterface

// File: rtl/cbrt_seq.sv
// Iterative floor(cbrt(b)) by digit recurrence with a bit-serial multiplier; busy for ITER*(WIDTH+2) edges,
// start_i ignored while busy. CBRT_SEQ_REM_EN adds rem_bo = b - y^3.
module cbrt_seq #(
   parameter int WIDTH = 8
) (
   input  logic      clk_i,
   input  logic      rst_i,
   cbrt_seq_if.slave bus
);
   localparam int ITER = (WIDTH - 1) / 3 + 1;
   localparam int TW   = 2 * WIDTH + 2;
   localparam int SW   = $clog2(3 * ITER + 1);
   localparam int CW   = $clog2(WIDTH);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_CMP} state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_x;
   logic [WIDTH-1:0]   r_y;
   logic [SW-1:0]      r_s;
   logic [2*WIDTH-1:0] r_mcd;
   logic [WIDTH-1:0]   r_mpl;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic               r_busy;
   logic [WIDTH-1:0]   r_y_bo;
`ifdef CBRT_SEQ_REM_EN
   logic [WIDTH-1:0]   r_rem_bo;
`endif

   logic [WIDTH-1:0]   w_ysh;
   logic [TW-1:0]      w_acc_x;
   logic [TW-1:0]      w_t;
   logic               w_ge;
   logic [WIDTH-1:0]   w_x_nxt;
   logic [WIDTH-1:0]   w_y_nxt;

   // Trial step: (2y+1)^3 - (2y)^3 = 3*y'(y'+1)+1, scaled to the current digit position.
   assign w_ysh   = r_y << 1;
   assign w_acc_x = {2'b00, r_acc};
   assign w_t     = ((w_acc_x << 1) + w_acc_x + TW'(1)) << r_s;
   assign w_ge    = {{(TW - WIDTH){1'b0}}, r_x} >= w_t;
   assign w_x_nxt = w_ge ? (r_x - w_t[WIDTH-1:0]) : r_x;
   assign w_y_nxt = w_ge ? (r_y + WIDTH'(1)) : r_y;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state  <= ST_IDLE;
         r_x      <= '0;
         r_y      <= '0;
         r_s      <= '0;
         r_mcd    <= '0;
         r_mpl    <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_y_bo   <= '0;
`ifdef CBRT_SEQ_REM_EN
         r_rem_bo <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start_i) begin
                  r_x     <= bus.b_bi;
                  r_y     <= '0;
                  r_s     <= SW'(3 * (ITER - 1));
                  r_busy  <= 1'b1;
                  r_state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_y     <= w_ysh;
               r_mcd   <= {{WIDTH{1'b0}}, w_ysh};
               r_mpl   <= w_ysh + WIDTH'(1);
               r_acc   <= '0;
               r_cnt   <= '0;
               r_state <= ST_MUL;
            end
            ST_MUL: begin
               r_acc <= r_acc + (r_mpl[0] ? r_mcd : '0);
               r_mcd <= r_mcd << 1;
               r_mpl <= r_mpl >> 1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state <= ST_CMP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_CMP: begin
               r_x <= w_x_nxt;
               r_y <= w_y_nxt;
               // The last digit publishes directly so busy spans exactly ITER*(WIDTH+2) edges.
               if (r_s == '0) begin
                  r_y_bo   <= w_y_nxt;
`ifdef CBRT_SEQ_REM_EN
                  r_rem_bo <= w_x_nxt;
`endif
                  r_busy   <= 1'b0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_s     <= r_s - SW'(3);
                  r_state <= ST_SHIFT;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy_o = r_busy;
   assign bus.y_bo   = r_y_bo;
`ifdef CBRT_SEQ_REM_EN
   assign bus.rem_bo = r_rem_bo;
`endif
endmodule

// File: tb/tb_cbrt_seq.sv
// Bench for cbrt_seq: directed boundary cases, abort/ignore scenarios and a shuffled full sweep with noisy inputs.
module tb_cbrt_seq;
   localparam int WIDTH = 8;
   localparam int LAT   = 30;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cbrt_seq_if #(.WIDTH(WIDTH)) bus ();
   cbrt_seq #(.WIDTH(WIDTH)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   int last_y = 0;
   int last_rem = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_root(input int b);
      int r = 0;
      while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
      return r;
   endfunction

   // Called at a falling edge; the accepting edge is the next rising edge.
   task automatic start_op(input int b);
      bus.start_i = 1'b1;
      bus.b_bi    = WIDTH'(b);
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   task automatic wait_done(input bit noisy, output int cyc);
      cyc = 0;
      while (bus.busy_o === 1'b1 && cyc < 200) begin
         if (noisy) begin
            bus.b_bi    = WIDTH'($urandom);
            bus.start_i = (cyc < LAT - 5) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      bus.start_i = 1'b0;
   endtask

   task automatic op(input int b, input bit noisy, input string tag);
      int cyc;
      int exp_y;
      start_op(b);
      chk({tag, "_accept"}, 32'(bus.busy_o), 32'd1);
      chk({tag, "_hold"}, 32'(bus.y_bo), 32'(last_y));
      wait_done(noisy, cyc);
      exp_y = ref_root(b);
      chk({tag, "_lat"}, 32'(cyc), 32'(LAT));
      chk({tag, "_y"}, 32'(bus.y_bo), 32'(exp_y));
`ifdef CBRT_SEQ_REM_EN
      chk({tag, "_rem"}, 32'(bus.rem_bo), 32'(b - exp_y * exp_y * exp_y));
      last_rem = b - exp_y * exp_y * exp_y;
`endif
      last_y = exp_y;
   endtask

   initial begin
      int cyc;
      int perm[256];
      int dir_b[7];
      bus.start_i = 1'b0;
      bus.b_bi    = '0;
      rst_n       = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_y", 32'(bus.y_bo), 32'd0);
`ifdef CBRT_SEQ_REM_EN
      chk("rst_rem", 32'(bus.rem_bo), 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      op(0, 1'b0, "zero");
      dir_b = '{27, 64, 125, 216, 26, 63, 255};
      foreach (dir_b[i]) op(dir_b[i], 1'b0, "dir");

      // A second start while busy must neither restart nor stretch the window.
      start_op(8);
      repeat (4) @(negedge clk);
      bus.start_i = 1'b1;
      bus.b_bi    = WIDTH'(125);
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.b_bi    = '0;
      wait_done(1'b0, cyc);
      chk("ign_lat", 32'(cyc + 5), 32'(LAT));
      chk("ign_y", 32'(bus.y_bo), 32'd2);
      repeat (3) @(negedge clk);
      chk("ign_idle", 32'(bus.busy_o), 32'd0);
      last_y = 2;

      // Reset mid-operation aborts without emitting anything.
      start_op(125);
      repeat (11) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy_o), 32'd0);
      chk("abort_y", 32'(bus.y_bo), 32'd0);
      last_y = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op(1, 1'b0, "post_rst");

      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j;
         int t;
         j       = $urandom_range(0, i);
         t       = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
      for (int i = 0; i < 256; i++) op(perm[i], 1'b1, "sweep");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
